// File: rtl/uart_pkg.sv
// Shared types, widths and helpers for the UART receive controller.
package uart_pkg;

    localparam int unsigned BAUD_W     = 20;
    localparam int unsigned TIMEOUT_W  = 24;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DRAIN_BITS = 16;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rx_ctrl_state_t;

    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
        return (&v) ? v : v + TIMEOUT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with a registered, write-through head (rd_data).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_n;
    logic [AW:0]       count_n;
    logic              do_rd;
    logic              do_wr;

    always_comb begin
        do_rd    = rd_en && (count != '0);
        do_wr    = wr_en && ((count != (AW+1)'(DEPTH)) || do_rd);
        count_n  = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        rd_ptr_n = rd_ptr + AW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Head register: bypass the write when the written entry becomes the head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            empty  <= (count_n == '0);
            full   <= (count_n == (AW+1)'(DEPTH));
            if (do_wr && (count == (AW+1)'(do_rd))) begin
                rd_data <= wr_data;
            end else if (count_n != '0) begin
                rd_data <= mem[rd_ptr_n];
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: OFF/RUN/DRAIN sequencing, receive FIFO, interrupts.
// Optional idle-timeout interrupt enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_rx_en_i,
    input  logic [BAUD_W-1:0]    cfg_baudrate_i,
    input  logic [AW:0]          cfg_thresh_i,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    input  logic                 irq_clr_i,
    output logic                 rx_en_o,
    output logic [BAUD_W-1:0]    baudrate_o,
    output logic                 full_o,
    input  logic [DATA_W-1:0]    rx_data_i,
    input  logic                 rx_valid_i,
    input  logic                 rd_en_i,
    output logic [DATA_W-1:0]    rd_data_o,
    output logic                 empty_o,
    output logic [AW:0]          count_o,
    output logic                 thresh_irq_o,
    output logic                 timeout_irq_o,
    output logic                 overrun_o
);

    rx_ctrl_state_t       state;
    rx_ctrl_state_t       state_n;
    logic                 rx_en_n;
    logic [BAUD_W-1:0]    baud_n;
    logic [TIMEOUT_W-1:0] since_valid;
    logic [TIMEOUT_W-1:0] drain_idle;
    logic [TIMEOUT_W-1:0] frame_win;
    logic [TIMEOUT_W-1:0] drain_lim;
    logic                 seen;
    logic                 recent;
    logic                 drain_done;
    logic                 wr_en;
    logic                 ovr_set;

    // A frame counts as recent if rx_valid was seen outside OFF within 11 bit times.
    always_comb begin
        frame_win  = TIMEOUT_W'(baudrate_o) * TIMEOUT_W'(FRAME_BITS);
        drain_lim  = TIMEOUT_W'(baudrate_o) * TIMEOUT_W'(DRAIN_BITS);
        recent     = rx_valid_i || (seen && (since_valid < frame_win));
        drain_done = drain_idle >= (drain_lim - TIMEOUT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OFF;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            OFF: begin
                if (cfg_rx_en_i && (cfg_baudrate_i != '0)) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!cfg_rx_en_i) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (cfg_rx_en_i) begin
                    state_n = RUN;
                end else if (!recent || (drain_done && !rx_valid_i)) begin
                    state_n = OFF;
                end
            end
            default: state_n = OFF;
        endcase
    end

    always_comb begin
        rx_en_n = (state_n == RUN);
        baud_n  = baudrate_o;
        if (state == OFF) begin
            baud_n = cfg_baudrate_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_en_o    <= 1'b0;
            baudrate_o <= '0;
        end else begin
            rx_en_o    <= rx_en_n;
            baudrate_o <= baud_n;
        end
    end

    // Frame history and drain idle tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen        <= 1'b0;
            since_valid <= '0;
            drain_idle  <= '0;
        end else begin
            if (state == OFF) begin
                seen <= 1'b0;
            end else if (rx_valid_i) begin
                seen <= 1'b1;
            end
            since_valid <= rx_valid_i ? '0 : sat_inc(since_valid);
            drain_idle  <= ((state != DRAIN) || rx_valid_i) ? '0 : sat_inc(drain_idle);
        end
    end

    assign wr_en   = rx_valid_i && ((count_o != (AW+1)'(DEPTH)) || rd_en_i);
    assign ovr_set = rx_valid_i && (count_o == (AW+1)'(DEPTH)) && !rd_en_i;

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (rx_data_i),
        .rd_en   (rd_en_i),
        .rd_data (rd_data_o),
        .count   (count_o),
        .empty   (empty_o),
        .full    (full_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_o <= 1'b0;
        end else if (ovr_set) begin
            overrun_o <= 1'b1;
        end else if (irq_clr_i) begin
            overrun_o <= 1'b0;
        end
    end

    assign thresh_irq_o = (cfg_thresh_i != '0) && (count_o >= cfg_thresh_i);

`ifdef UART_RX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] idle_cnt;
    logic [TIMEOUT_W-1:0] idle_n;
    logic                 idle_clr;
    logic                 tmo_set;

    // Idle time only accrues while data sits unread with no traffic.
    always_comb begin
        idle_clr = rx_valid_i || rd_en_i || empty_o;
        idle_n   = idle_clr ? '0 : sat_inc(idle_cnt);
        tmo_set  = !idle_clr && (cfg_timeout_i != '0) && (idle_n == cfg_timeout_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt      <= '0;
            timeout_irq_o <= 1'b0;
        end else begin
            idle_cnt <= idle_n;
            if (tmo_set) begin
                timeout_irq_o <= 1'b1;
            end else if (irq_clr_i) begin
                timeout_irq_o <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^cfg_timeout_i;
    assign timeout_irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: timestamp/queue reference model plus directed literals.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_rx_en;
    logic [19:0] cfg_baud;
    logic [4:0]  cfg_thresh;
    logic [23:0] cfg_timeout;
    logic        irq_clr;
    logic        rx_en_o;
    logic [19:0] baudrate_o;
    logic        full_o;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rd_en;
    logic [7:0]  rd_data_o;
    logic        empty_o;
    logic [4:0]  count_o;
    logic        thresh_irq_o;
    logic        timeout_irq_o;
    logic        overrun_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_rx_en_i    (cfg_rx_en),
        .cfg_baudrate_i (cfg_baud),
        .cfg_thresh_i   (cfg_thresh),
        .cfg_timeout_i  (cfg_timeout),
        .irq_clr_i      (irq_clr),
        .rx_en_o        (rx_en_o),
        .baudrate_o     (baudrate_o),
        .full_o         (full_o),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .rd_en_i        (rd_en),
        .rd_data_o      (rd_data_o),
        .empty_o        (empty_o),
        .count_o        (count_o),
        .thresh_irq_o   (thresh_irq_o),
        .timeout_irq_o  (timeout_irq_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue, mode number and event timestamps (edge indices).
    byte unsigned q[$];
    int     m_mode;      // 0 = off, 1 = receiving, 2 = draining
    int     m_baud;
    bit     m_rx_en, m_ovr, m_tmo, m_seen;
    longint t = 0, last_valid_t = 0, drain_ref_t = 0, last_clr_t = 0;

    always @(posedge clk) begin
        int sz, nxt;
        bit recent, tclr, tset;
        t++;
        if (!rst_n) begin
            q.delete();
            m_mode = 0; m_baud = 0; m_rx_en = 0; m_ovr = 0; m_tmo = 0; m_seen = 0;
            last_clr_t = t;
        end else begin
            sz = q.size();
            tclr = rx_valid || rd_en || (sz == 0);
            if (tclr) last_clr_t = t;
            tset = !tclr && (cfg_timeout != 0) && ((t - last_clr_t) == longint'(cfg_timeout));
`ifdef UART_RX_TIMEOUT_EN
            if (tset) m_tmo = 1; else if (irq_clr) m_tmo = 0;
`else
            m_tmo = 0;
`endif
            if (rx_valid && sz == DEPTH && !rd_en) m_ovr = 1;
            else if (irq_clr) m_ovr = 0;
            if (rd_en && sz > 0) void'(q.pop_front());
            if (rx_valid && (sz < DEPTH || rd_en)) q.push_back(rx_data);

            recent = rx_valid || (m_seen && (t - last_valid_t) <= 11 * m_baud);
            nxt = m_mode;
            case (m_mode)
                0: begin
                    m_baud = int'(cfg_baud);
                    if (cfg_rx_en && cfg_baud != 0) nxt = 1;
                end
                1: if (!cfg_rx_en) begin nxt = 2; drain_ref_t = t; end
                default: begin
                    if (cfg_rx_en) nxt = 1;
                    else if (!recent || (!rx_valid && (t - drain_ref_t) >= 16 * m_baud)) nxt = 0;
                end
            endcase
            if (m_mode == 0) m_seen = 0;
            else if (rx_valid) begin
                m_seen = 1;
                last_valid_t = t;
                if (m_mode == 2) drain_ref_t = t;
            end
            m_mode  = nxt;
            m_rx_en = (nxt == 1);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("rx_en", rx_en_o, m_rx_en);
            check("baudrate", baudrate_o, m_baud);
            check("count", count_o, q.size());
            check("empty", empty_o, q.size() == 0);
            check("full", full_o, q.size() == DEPTH);
            check("thresh_irq", thresh_irq_o, (cfg_thresh != 0) && (q.size() >= cfg_thresh));
            check("overrun", overrun_o, m_ovr);
            check("timeout_irq", timeout_irq_o, m_tmo);
            if (q.size() != 0) check("rd_data", rd_data_o, q[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, k;
        rst_n = 0; cfg_rx_en = 0; cfg_baud = 0; cfg_thresh = 0; cfg_timeout = 0;
        irq_clr = 0; rx_data = 0; rx_valid = 0; rd_en = 0;
        tick();
        chk_on = 1;
        tick(); tick();
        check("rst_rx_en", rx_en_o, 0);
        check("rst_baud", baudrate_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_count", count_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_overrun", overrun_o, 0);

        // Enable with zero divider stays off; a valid divider starts reception.
        rst_n = 1; cfg_rx_en = 1;
        repeat (3) tick();
        check("zero_baud_off", rx_en_o, 0);
        cfg_baud = 20'd868;
        tick();
        check("run_rx_en", rx_en_o, 1);
        check("run_baud", baudrate_o, 868);

        cfg_thresh = 5'd4;
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h11 * (i + 1)));
            if (i == 2) check("thresh_below", thresh_irq_o, 0);
            if (i == 3) check("thresh_at", thresh_irq_o, 1);
            tick();
        end
        check("count_five", count_o, 5);
        for (int i = 0; i < 5; i++) begin
            check("pop_order", rd_data_o, 8'(8'h11 * (i + 1)));
            pop();
        end
        check("drained_empty", empty_o, 1);
        check("drained_thresh", thresh_irq_o, 0);

        for (int i = 0; i < 16; i++) begin
            push(8'(8'hA0 + i));
            tick();
        end
        check("full_at_16", full_o, 1);
        push(8'hEE);
        check("overrun_set", overrun_o, 1);
        check("overrun_count", count_o, 16);
        irq_clr = 1; tick(); irq_clr = 0;
        check("overrun_clr", overrun_o, 0);

        // Simultaneous push and pop while full.
        rx_data = 8'h77; rx_valid = 1; rd_en = 1;
        tick();
        rx_valid = 0; rd_en = 0;
        check("full_rw_count", count_o, 16);
        check("full_rw_no_ovr", overrun_o, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 0)  check("full_rw_head", rd_data_o, 8'hA1);
            if (i == 15) check("full_rw_tail", rd_data_o, 8'h77);
            pop();
        end

        // Baud changes are ignored until the controller is off again.
        cfg_baud = 20'd434;
        repeat (5) tick();
        check("baud_frozen_run", baudrate_o, 868);
        cfg_rx_en = 0;
        tick();
        check("drain_rx_en", rx_en_o, 0);
        check("baud_frozen_drain", baudrate_o, 868);
        w = 0;
        while (baudrate_o != 20'd434 && w < 20000) begin
            tick();
            w++;
        end
        check("drain_exit_baud", baudrate_o, 434);

        // Idle timeout measured from the last received byte.
        cfg_timeout = 24'd1000;
        push(8'h99);
        repeat (500) tick();
        check("tmo_not_yet", timeout_irq_o, 0);
        push(8'h9A);
        k = 0;
        while (!timeout_irq_o && k < 1100) begin
            tick();
            k++;
        end
`ifdef UART_RX_TIMEOUT_EN
        check("tmo_latency", k, 1000);
`else
        check("tmo_disabled", timeout_irq_o, 0);
`endif
        irq_clr = 1; tick(); irq_clr = 0;
        check("tmo_clr", timeout_irq_o, 0);
        pop(); pop();
        check("tmo_empty", empty_o, 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) cfg_rx_en = ~cfg_rx_en;
            if ($urandom_range(0, 29) == 0) cfg_baud = 20'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) cfg_thresh = 5'($urandom_range(0, 16));
            if ($urandom_range(0, 99) == 0) cfg_timeout = 24'($urandom_range(0, 40));
            rx_valid = !rx_valid && ($urandom_range(0, 2) != 0);
            rx_data  = 8'($urandom);
            rd_en    = (i < 2000) ? ($urandom_range(0, 6) == 0) : ($urandom_range(0, 2) == 0);
            irq_clr  = ($urandom_range(0, 24) == 0);
            tick();
        end
        rx_valid = 0; rd_en = 0; irq_clr = 0; rst_n = 1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
